// File: rtl/frame_scanner.sv
// rtl/frame_scanner.sv - raster scanner that plots one full frame per start request
// Walks every (x,y) once, forwarding the sprite renderer's colour to the VGA adapter one cycle later.
module frame_scanner #(
  parameter int         H_MAX        = 160,
  parameter int         V_MAX        = 120,
  parameter logic [2:0] BLANK_COLOUR = 3'b000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       blank,
  input  logic [7:0] yasu_x_in,
  input  logic [6:0] yasu_y_in,
  output logic [7:0] scan_x,
  output logic [6:0] scan_y,
  output logic [7:0] sprite_x,
  output logic [6:0] sprite_y,
  input  logic [2:0] pix_color,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  localparam logic [7:0] X_LAST = 8'(H_MAX - 1);
  localparam logic [6:0] Y_LAST = 7'(V_MAX - 1);

  state_e     state_q, state_d;
  logic [7:0] scan_x_q, scan_x_d;
  logic [6:0] scan_y_q, scan_y_d;
  logic [7:0] sprite_x_q, sprite_x_d;
  logic [6:0] sprite_y_q, sprite_y_d;
  logic       blank_q, blank_d;
  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;
  logic       vga_plot_q, vga_plot_d;
  logic       done_q, done_d;

  always_comb begin
    state_d      = state_q;
    scan_x_d     = scan_x_q;
    scan_y_d     = scan_y_q;
    sprite_x_d   = sprite_x_q;
    sprite_y_d   = sprite_y_q;
    blank_d      = blank_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SCAN;
          scan_x_d   = '0;
          scan_y_d   = '0;
          sprite_x_d = yasu_x_in;
          sprite_y_d = yasu_y_in;
          blank_d    = blank;
        end
      end
      SCAN: begin
        // The renderer answers combinationally for the current scan point, so register it here.
        vga_x_d      = scan_x_q;
        vga_y_d      = scan_y_q;
        vga_colour_d = blank_q ? BLANK_COLOUR : pix_color;
        vga_plot_d   = 1'b1;
        if (scan_x_q == X_LAST) begin
          scan_x_d = '0;
          if (scan_y_q == Y_LAST) begin
            scan_y_d = '0;
            state_d  = DONE;
          end else begin
            scan_y_d = scan_y_q + 7'd1;
          end
        end else begin
          scan_x_d = scan_x_q + 8'd1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      scan_x_q     <= '0;
      scan_y_q     <= '0;
      sprite_x_q   <= '0;
      sprite_y_q   <= '0;
      blank_q      <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      scan_x_q     <= scan_x_d;
      scan_y_q     <= scan_y_d;
      sprite_x_q   <= sprite_x_d;
      sprite_y_q   <= sprite_y_d;
      blank_q      <= blank_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      done_q       <= done_d;
    end
  end

  assign scan_x     = scan_x_q;
  assign scan_y     = scan_y_q;
  assign sprite_x   = sprite_x_q;
  assign sprite_y   = sprite_y_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_frame_scanner.sv
// tb/tb_frame_scanner.sv - directed/random frame bench for frame_scanner
// Expected plots are derived from raster index k: x = k % H, y = k / H.
module tb_frame_scanner;

  localparam int H = 160;
  localparam int V = 120;

  logic       clock = 1'b0;
  logic       resetn;
  logic       start;
  logic       blank;
  logic [7:0] yasu_x_in;
  logic [6:0] yasu_y_in;
  logic [7:0] scan_x;
  logic [6:0] scan_y;
  logic [7:0] sprite_x;
  logic [6:0] sprite_y;
  logic [2:0] pix_color;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;
  logic       ren_const;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;

  frame_scanner dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .blank      (blank),
    .yasu_x_in  (yasu_x_in),
    .yasu_y_in  (yasu_y_in),
    .scan_x     (scan_x),
    .scan_y     (scan_y),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .pix_color  (pix_color),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  // Stand-in sprite renderer: a position-dependent pattern, or a fixed colour.
  function automatic logic [2:0] ren(input int x, input int y, input int sx, input int sy);
    return 3'((x * 3 + y * 5 + sx + sy) % 8);
  endfunction

  assign pix_color = ren_const ? 3'b011
                   : ren(int'(scan_x), int'(scan_y), int'(sprite_x), int'(sprite_y));

  always @(negedge clock) if (done === 1'b1) n_done++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {13'd0, scan_x, scan_y, sprite_x, sprite_y, vga_x, vga_y, vga_colour,
            vga_plot, busy, done};
  endfunction

  // Follows one frame from its start edge to its done cycle and checks it against the raster model.
  task automatic watch_frame(input int sx, input int sy, input bit blk, input bit single);
    int cyc = 0, k = 0, bad = 0, first = -1, last = -1, done_cyc = -1;
    int sprite_bad = 0, range_bad = 0;
    logic plot_at_done = 1'b1, busy_at_done = 1'b1;
    logic [2:0] ec;
    while (done_cyc < 0 && cyc < H * V + 50) begin
      @(posedge clock); #1; cyc++;
      if (cyc == 1) check("busy_after_start", busy, 1);
      if (single) begin
        if (cyc == 1)         start = 1'b0;
        if (cyc == 100)       start = 1'b1;
        if (cyc == 101)       start = 1'b0;
        if (cyc == H * V / 2) yasu_x_in = 8'd90;
      end
      if (vga_plot === 1'b1) begin
        if (first < 0) first = cyc;
        last = cyc;
        ec = blk ? 3'b000 : ren(k % H, k / H, sx, sy);
        if (vga_x !== 8'(k % H) || vga_y !== 7'(k / H) || vga_colour !== ec) bad++;
        k++;
        if (single && k == H * V) start = 1'b1;
      end
      if (sprite_x !== 8'(sx) || sprite_y !== 7'(sy)) sprite_bad++;
      if (int'(scan_x) >= H || int'(scan_y) >= V) range_bad++;
      if (done === 1'b1) begin
        done_cyc     = cyc;
        plot_at_done = vga_plot;
        busy_at_done = busy;
        if (single) start = 1'b0;
      end
    end
    check("done_seen", done_cyc > 0, 1);
    check("plot_count", k, H * V);
    check("plot_contiguous", last - first + 1, H * V);
    check("first_plot_latency", first, 2);
    check("done_after_last_plot", done_cyc, last + 1);
    check("pixel_mismatches", bad, 0);
    check("sprite_held", sprite_bad, 0);
    check("scan_range", range_bad, 0);
    check("plot_low_at_done", plot_at_done, 0);
    check("idle_at_done", busy_at_done, 0);
  endtask

  initial begin
    int sx, sy, idle_bad, found, done_before;
    resetn = 1'b0; start = 1'b0; blank = 1'b0;
    yasu_x_in = '0; yasu_y_in = '0; ren_const = 1'b0;
    repeat (3) @(posedge clock);
    #1 check("reset_outputs", all_outs(), 0);
    @(negedge clock) resetn = 1'b1;

    // Single-start frame with ignored start pulses in SCAN/DONE and a mid-frame yasu_x change.
    @(posedge clock); #1;
    start = 1'b1; blank = 1'b0; yasu_x_in = 8'd40; yasu_y_in = 7'd60;
    watch_frame(40, 60, 1'b0, 1'b1);
    idle_bad = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (busy !== 1'b0 || vga_plot !== 1'b0 || done !== 1'b0) idle_bad++;
    end
    check("no_second_frame", idle_bad, 0);
    check("sprite_x_after_frame", sprite_x, 40);

    // Next frame latches 90, then is aborted by reset at plotted pixel (80,50).
    start = 1'b1; yasu_y_in = 7'($urandom_range(0, V - 1));
    @(posedge clock); #1;
    start = 1'b0;
    check("sprite_x_relatch", sprite_x, 90);
    check("sprite_y_relatch", sprite_y, yasu_y_in);
    found = 0;
    for (int i = 0; i < H * V && found == 0; i++) begin
      @(posedge clock); #1;
      if (vga_plot === 1'b1 && vga_x == 8'd80 && vga_y == 7'd50) found = 1;
    end
    check("reached_80_50", found, 1);
    done_before = n_done;
    resetn = 1'b0;
    #1 check("async_reset_outputs", all_outs(), 0);
    repeat (2) @(posedge clock);
    @(negedge clock) resetn = 1'b1;
    idle_bad = 0;
    repeat (30) begin
      @(posedge clock); #1;
      if (busy !== 1'b0 || vga_plot !== 1'b0) idle_bad++;
    end
    check("idle_after_abort", idle_bad, 0);
    check("no_done_after_abort", n_done, done_before);

    // start held high for three back-to-back frames; the middle one is blank.
    sx = $urandom_range(0, H - 1); sy = $urandom_range(0, V - 1);
    start = 1'b1; blank = 1'b0; ren_const = 1'b0;
    yasu_x_in = 8'(sx); yasu_y_in = 7'(sy);
    watch_frame(sx, sy, 1'b0, 1'b0);
    sx = $urandom_range(0, H - 1); sy = $urandom_range(0, V - 1);
    blank = 1'b1; ren_const = 1'b1;
    yasu_x_in = 8'(sx); yasu_y_in = 7'(sy);
    watch_frame(sx, sy, 1'b1, 1'b0);
    sx = $urandom_range(0, H - 1); sy = $urandom_range(0, V - 1);
    blank = 1'b0; ren_const = 1'b0;
    yasu_x_in = 8'(sx); yasu_y_in = 7'(sy);
    watch_frame(sx, sy, 1'b0, 1'b0);
    start = 1'b0;
    idle_bad = 0;
    repeat (30) begin
      @(posedge clock); #1;
      if (busy !== 1'b0 || vga_plot !== 1'b0 || done !== 1'b0) idle_bad++;
    end
    check("idle_after_held", idle_bad, 0);
    check("total_done_pulses", n_done, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
